instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Instruction fetch/sequencer; the supplying end of the decoder's control interface.
//  - Keeps the program counter and reads 9-bit instruction words {c_in[8:6], c_reg[5:3], c_arg[2:0]} from program memory.
//  - Presents each word to the Control decoder and consumes the decoder's PC/jump feedback to choose the next address.
//  - Sits between program ROM and Control; ALU status flags feed the condition logic.
// PARAMETERS
//  PC_W      8    program counter / memory address width
//  RESET_PC  0    PC value loaded on reset
//  TIMEOUT   15   max wait cycles for i_Mem_Ack (used only with IFETCH_TIMEOUT_EN)
// PORTS
//  i_Clk             in   1     clock; all logic on rising edge
//  i_Rst             in   1     synchronous, active-high reset
//  i_Run             in   1     start fetching from IDLE
//  o_Mem_Req         out  1     program memory read request
//  o_Mem_Addr        out  PC_W  read address (= PC)
//  i_Mem_Ack         in   1     read complete; i_Mem_Data valid
//  i_Mem_Data        in   9     instruction word
//  o_Instrucciones   out  9     instruction to decoder
//  o_Instr_Valid     out  1     o_Instrucciones valid
//  i_Instr_Ready     in   1     downstream accepts instruction
//  i_Control_PC      in   1     decoder: 1 = sequential, 0 = jump instruction
//  i_Control_Saltos  in   4     decoder: [3] jump flag, [2:0] condition code
//  i_Salto_Dir       in   PC_W  jump target address
//  i_Flags           in   3     {N, C, Z} from ALU
//  o_Halted          out  1     halt instruction executed
//  o_Fault           out  1     memory timeout (IFETCH_TIMEOUT_EN only; else tied 0)
// BEHAVIOUR
//  Reset (i_Rst=1 at edge, any state, mid-transaction included):
//   - state=IDLE, PC=RESET_PC; o_Mem_Req=0, o_Instr_Valid=0, o_Instrucciones=0, o_Halted=0, o_Fault=0.
//   - A pending memory request is abandoned; a late i_Mem_Ack is ignored.
//  States IDLE, FETCH, ISSUE, HALT (+ FAULT with macro):
//   - IDLE: outputs idle; i_Run=1 -> FETCH.
//   - FETCH: o_Mem_Req=1, o_Mem_Addr=PC, both held stable until i_Mem_Ack=1 is sampled.
//     On ack, latch i_Mem_Data into o_Instrucciones and go to ISSUE; o_Mem_Req=0 in the next cycle.
//   - ISSUE: o_Instr_Valid=1; o_Instrucciones held until i_Instr_Ready=1.
//     On the accept edge, sample i_Control_PC, i_Control_Saltos, i_Flags and i_Salto_Dir, then set the next PC.
//   - i_Mem_Ack outside FETCH is ignored.
//  Next PC (evaluated on the ISSUE accept edge):
//   - jump = (i_Control_PC==0) && i_Control_Saltos[3] && cond.
//   - cond by [2:0]: 000 always; 001 Z; 010 !Z; 011 C; 100 !C; 101 N; 110 !N; 111 HALT.
//   - Code 111 with the jump qualifier -> HALT, PC unchanged, o_Halted=1.
//   - jump -> PC=i_Salto_Dir, else PC=PC+1 mod 2^PC_W (max wraps to 0); then -> FETCH.
//   - Inconsistent feedback (i_Control_PC=0 with Saltos[3]=0, or PC=1 with Saltos[3]=1) -> sequential PC+1.
//  HALT: o_Mem_Req=0, o_Instr_Valid=0, o_Halted=1; leaves only on reset (i_Run ignored).
//  Throughput: min 2 cycles/instruction (ack and ready both high on first cycle).
//  o_Mem_Req and o_Instr_Valid are never high together.
// CONFIGURATION
//  IFETCH_TIMEOUT_EN defined:
//   - Wait counter clears on entry to FETCH and increments each FETCH cycle without ack.
//   - After TIMEOUT wait cycles without ack -> FAULT: o_Fault=1, o_Mem_Req=0, PC frozen; leaves only on reset.
//   - Ack on the final allowed cycle is accepted normally.
//  Undefined: no counter, FETCH waits indefinitely, o_Fault tied 0.
// TESTING
//  1 Reset, i_Run=1, ack+ready each first cycle, ROM 0..3 sequential -> o_Mem_Addr 0,1,2,3; valid every 2nd cycle.
//  2 Word 9'b111_000_001 (JZ): feedback PC=0, Saltos=4'b1001, Z=1, Dir=8'h40 -> next addr 8'h40; Z=0 -> PC+1.
//  3 PC=8'hFF, sequential instruction -> next o_Mem_Addr=8'h00.
//  4 Saltos=4'b1111, PC=0 -> o_Halted=1 next cycle, o_Mem_Req stays 0 for 20 cycles; i_Rst -> IDLE, PC=0.
//  5 Ack delayed 3 cycles, ready delayed 2 -> o_Mem_Addr/o_Instrucciones stable throughout; early ack in ISSUE ignored.
//  6 i_Rst pulse mid-FETCH, then ack -> ack ignored, state IDLE, PC=RESET_PC.
//  7 Macro on, TIMEOUT=15, no ack -> o_Fault=1 after 15 FETCH cycles; ack on the 15th cycle -> no fault.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch/sequencer: walks the PC, reads 9-bit words from program ROM, resolves decoder jump feedback.
// Latency: 2 cycles/instruction minimum (one FETCH cycle, one ISSUE cycle); one instruction in flight.
// Backpressure: waits for i_Mem_Ack in FETCH and i_Instr_Ready in ISSUE; IFETCH_TIMEOUT_EN adds a fetch watchdog.
module instruction_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic            i_Run,
    output logic            o_Mem_Req,
    output logic [PC_W-1:0] o_Mem_Addr,
    input  logic            i_Mem_Ack,
    input  logic [8:0]      i_Mem_Data,
    output logic [8:0]      o_Instrucciones,
    output logic            o_Instr_Valid,
    input  logic            i_Instr_Ready,
    input  logic            i_Control_PC,
    input  logic [3:0]      i_Control_Saltos,
    input  logic [PC_W-1:0] i_Salto_Dir,
    input  logic [2:0]      i_Flags,
    output logic            o_Halted,
    output logic            o_Fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [8:0]      instr, instr_nxt;

    logic flag_n, flag_c, flag_z;
    logic qual, cond, take_jump, take_halt;

    assign flag_n = i_Flags[2];
    assign flag_c = i_Flags[1];
    assign flag_z = i_Flags[0];

    // Only a jump-type instruction with a consistent jump flag may redirect or halt.
    assign qual = !i_Control_PC && i_Control_Saltos[3];

    always_comb begin
        cond = 1'b0;
        case (i_Control_Saltos[2:0])
            3'b000:  cond = 1'b1;
            3'b001:  cond = flag_z;
            3'b010:  cond = !flag_z;
            3'b011:  cond = flag_c;
            3'b100:  cond = !flag_c;
            3'b101:  cond = flag_n;
            3'b110:  cond = !flag_n;
            default: cond = 1'b0;
        endcase
    end

    assign take_halt = qual && (i_Control_Saltos[2:0] == 3'b111);
    assign take_jump = qual && cond;

`ifdef IFETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            instr <= instr_nxt;
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt <= wait_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
`ifdef IFETCH_TIMEOUT_EN
        wait_cnt_nxt = wait_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (i_Run) begin
                    state_nxt = S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                end
            end
            S_FETCH: begin
                if (i_Mem_Ack) begin
                    instr_nxt = i_Mem_Data;
                    state_nxt = S_ISSUE;
                end
`ifdef IFETCH_TIMEOUT_EN
                // wait_cnt holds the number of earlier ack-less cycles in this fetch.
                else if (wait_cnt == CNT_LAST) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
`endif
            end
            S_ISSUE: begin
                if (i_Instr_Ready) begin
                    if (take_halt) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = take_jump ? i_Salto_Dir : pc + PC_W'(1);
                        state_nxt = S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
                        wait_cnt_nxt = '0;
`endif
                    end
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    assign o_Mem_Req       = (state == S_FETCH);
    assign o_Mem_Addr      = pc;
    assign o_Instr_Valid   = (state == S_ISSUE);
    assign o_Instrucciones = instr;
    assign o_Halted        = (state == S_HALT);
`ifdef IFETCH_TIMEOUT_EN
    assign o_Fault         = (state == S_FAULT);
`else
    assign o_Fault         = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequencing, conditional jumps, wrap, halt, stalls, reset, timeout.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [8:0] mem_data;
    logic [8:0] instr;
    logic       instr_vld;
    logic       instr_rdy;
    logic       ctrl_pc;
    logic [3:0] ctrl_saltos;
    logic [7:0] salto_dir;
    logic [2:0] flags;
    logic       halted;
    logic       fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.PC_W(8), .RESET_PC(8'h00), .TIMEOUT(15)) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_Run            (run),
        .o_Mem_Req        (mem_req),
        .o_Mem_Addr       (mem_addr),
        .i_Mem_Ack        (mem_ack),
        .i_Mem_Data       (mem_data),
        .o_Instrucciones  (instr),
        .o_Instr_Valid    (instr_vld),
        .i_Instr_Ready    (instr_rdy),
        .i_Control_PC     (ctrl_pc),
        .i_Control_Saltos (ctrl_saltos),
        .i_Salto_Dir      (salto_dir),
        .i_Flags          (flags),
        .o_Halted         (halted),
        .o_Fault          (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FETCH cycle: check the request, then acknowledge with word d.
    task automatic fetch(input logic [7:0] exp_addr, input logic [8:0] d);
        @(negedge clk);
        instr_rdy = 1'b0;
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_vld", 32'(instr_vld), 32'd0);
        chk("fetch_addr", 32'(mem_addr), 32'(exp_addr));
        mem_ack  = 1'b1;
        mem_data = d;
    endtask

    // ISSUE cycle: check the presented word, then accept with the given feedback.
    task automatic issue(input logic [8:0] exp_instr, input logic cpc, input logic [3:0] sal,
                         input logic [2:0] fl, input logic [7:0] dir);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("issue_vld", 32'(instr_vld), 32'd1);
        chk("issue_req", 32'(mem_req), 32'd0);
        chk("issue_instr", 32'(instr), 32'(exp_instr));
        instr_rdy   = 1'b1;
        ctrl_pc     = cpc;
        ctrl_saltos = sal;
        flags       = fl;
        salto_dir   = dir;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = '0; instr_rdy = 1'b0;
        ctrl_pc = 1'b1; ctrl_saltos = '0; salto_dir = '0; flags = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_vld", 32'(instr_vld), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        run = 1'b1;

        // Sequential ROM 0..3 at full rate.
        for (int i = 0; i < 4; i++) begin
            fetch(8'(i), 9'(9'h010 + 9'h011 * i));
            issue(9'(9'h010 + 9'h011 * i), 1'b1, 4'b0000, 3'b000, 8'h00);
        end

        // JZ taken, JZ not taken, JC taken, two inconsistent feedbacks, JNN not taken, JMP to 0xFF.
        fetch(8'h04, 9'b111_000_001);
        issue(9'b111_000_001, 1'b0, 4'b1001, 3'b001, 8'h40);
        fetch(8'h40, 9'h1C1);
        issue(9'h1C1, 1'b0, 4'b1001, 3'b000, 8'h77);
        fetch(8'h41, 9'h0A3);
        issue(9'h0A3, 1'b0, 4'b1011, 3'b010, 8'h80);
        fetch(8'h80, 9'h055);
        issue(9'h055, 1'b1, 4'b1000, 3'b000, 8'h10);
        fetch(8'h81, 9'h066);
        issue(9'h066, 1'b0, 4'b0000, 3'b000, 8'h10);
        fetch(8'h82, 9'h077);
        issue(9'h077, 1'b0, 4'b1110, 3'b100, 8'h10);
        fetch(8'h83, 9'h088);
        issue(9'h088, 1'b0, 4'b1000, 3'b000, 8'hFF);

        // PC wraps from 0xFF to 0x00.
        fetch(8'hFF, 9'h099);
        issue(9'h099, 1'b1, 4'b0000, 3'b000, 8'h00);
        fetch(8'h00, 9'h0AA);
        issue(9'h0AA, 1'b1, 4'b0000, 3'b000, 8'h00);

        // Ack delayed 3 cycles, ready delayed 2 with a stray ack during ISSUE.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            instr_rdy = 1'b0;
            mem_ack   = 1'b0;
            mem_data  = 9'(9'h1AA ^ k);
            chk("stall_req", 32'(mem_req), 32'd1);
            chk("stall_addr", 32'(mem_addr), 32'h01);
        end
        fetch(8'h01, 9'h155);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_ack   = 1'b1;
            mem_data  = 9'h0F0;
            instr_rdy = 1'b0;
            chk("hold_vld", 32'(instr_vld), 32'd1);
            chk("hold_req", 32'(mem_req), 32'd0);
            chk("hold_instr", 32'(instr), 32'h155);
        end
        issue(9'h155, 1'b1, 4'b0000, 3'b000, 8'h00);

        // Halt instruction; i_Run and ack ignored afterwards.
        fetch(8'h02, 9'h1FF);
        issue(9'h1FF, 1'b0, 4'b1111, 3'b000, 8'h99);
        @(negedge clk);
        instr_rdy = 1'b0;
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_req", 32'(mem_req), 32'd0);
        chk("halt_vld", 32'(instr_vld), 32'd0);
        chk("halt_addr", 32'(mem_addr), 32'h02);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            run     = 1'b1;
            mem_ack = 1'b1;
            chk("halt_hold_req", 32'(mem_req), 32'd0);
            chk("halt_hold_flag", 32'(halted), 32'd1);
        end
        mem_ack = 1'b0;
        run     = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("halt_rst_flag", 32'(halted), 32'd0);
        chk("halt_rst_addr", 32'(mem_addr), 32'd0);
        chk("halt_rst_req", 32'(mem_req), 32'd0);
        chk("halt_rst_instr", 32'(instr), 32'd0);
        rst = 1'b0;
        run = 1'b1;

        // Reset mid-FETCH followed by a late ack.
        fetch(8'h00, 9'h123);
        issue(9'h123, 1'b1, 4'b0000, 3'b000, 8'h00);
        @(negedge clk);
        instr_rdy = 1'b0;
        chk("midrst_req", 32'(mem_req), 32'd1);
        chk("midrst_addr", 32'(mem_addr), 32'h01);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        run     = 1'b0;
        mem_ack = 1'b1;
        mem_data = 9'h1EE;
        chk("midrst_req0", 32'(mem_req), 32'd0);
        chk("midrst_pc", 32'(mem_addr), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_vld", 32'(instr_vld), 32'd0);
        chk("late_ack_instr", 32'(instr), 32'd0);
        run = 1'b1;

`ifdef IFETCH_TIMEOUT_EN
        // No ack: fault after 15 FETCH cycles.
        for (int k = 1; k <= 15; k++) @(negedge clk);
        chk("to_req15", 32'(mem_req), 32'd1);
        chk("to_fault15", 32'(fault), 32'd0);
        @(negedge clk);
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_req", 32'(mem_req), 32'd0);
        chk("to_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("to_rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        // Ack on the 15th cycle is still accepted.
        for (int k = 1; k <= 15; k++) @(negedge clk);
        mem_ack  = 1'b1;
        mem_data = 9'h0C3;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("to_late_vld", 32'(instr_vld), 32'd1);
        chk("to_late_fault", 32'(fault), 32'd0);
        chk("to_late_instr", 32'(instr), 32'h0C3);
`else
        // Without the watchdog a fetch waits indefinitely.
        for (int k = 0; k < 40; k++) @(negedge clk);
        chk("wait_req", 32'(mem_req), 32'd1);
        chk("wait_fault", 32'(fault), 32'd0);
        chk("wait_addr", 32'(mem_addr), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
